// File: rtl/ttt_turn_sched_if.sv
// Bus bundle for the tic-tac-toe turn scheduler: player controls in, board/status out.
interface ttt_turn_sched_if;
  logic        Start;
  logic        Ack;
  logic        BtnU;
  logic        BtnR;
  logic        BtnD;
  logic [3:0]  pos;
  logic [8:0]  board_x;
  logic [8:0]  board_o;
  logic        turn;
  logic        Qi;
  logic        Qp;
  logic        Qc;
  logic        Qd;
  logic        Xwins;
  logic        Owins;
  logic        draw;
  logic        reject;
  logic [11:0] P1s;
  logic [11:0] P2s;

  // Player / test side: drives controls, observes the game.
  modport master (
    output Start, Ack, BtnU, BtnR, BtnD,
    input  pos, board_x, board_o, turn, Qi, Qp, Qc, Qd,
    input  Xwins, Owins, draw, reject, P1s, P2s
  );

  // Scheduler side.
  modport slave (
    input  Start, Ack, BtnU, BtnR, BtnD,
    output pos, board_x, board_o, turn, Qi, Qp, Qc, Qd,
    output Xwins, Owins, draw, reject, P1s, P2s
  );
endinterface

// File: rtl/ttt_turn_sched.sv
// Tic-tac-toe turn scheduler: cursor movement, placement, line-by-line win check,
// draw detection and saturating per-player win counters.
module ttt_turn_sched #(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input logic             Clk,
  input logic             reset_n,
  ttt_turn_sched_if.slave bus
);

  // One-hot so the state register doubles as the Qi/Qp/Qc/Qd flags.
  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StPlay  = 4'b0010,
    StCheck = 4'b0100,
    StDone  = 4'b1000
  } state_e;

  state_e      state_q;
  logic [3:0]  pos_q;
  logic [3:0]  counter_q;
  logic [8:0]  bx_q;
  logic [8:0]  bo_q;
  logic        turn_q;
  logic [2:0]  k_q;
  logic        xw_q;
  logic        ow_q;
  logic        draw_q;
  logic        reject_q;
  logic [11:0] p1s_q;
  logic [11:0] p2s_q;

  logic [8:0]  line_mask;
  logic [8:0]  mover_cells;
  logic [8:0]  pos_mask;
  logic        line_won;
  logic        cell_taken;
  logic [3:0]  pos_right;
  logic [3:0]  pos_down;

  // Cell mask of the line currently under examination.
  always_comb begin
    line_mask = 9'h000;
    unique case (k_q)
      3'd0: line_mask = 9'h007;  // 0 1 2
      3'd1: line_mask = 9'h038;  // 3 4 5
      3'd2: line_mask = 9'h1c0;  // 6 7 8
      3'd3: line_mask = 9'h049;  // 0 3 6
      3'd4: line_mask = 9'h092;  // 1 4 7
      3'd5: line_mask = 9'h124;  // 2 5 8
      3'd6: line_mask = 9'h111;  // 0 4 8
      3'd7: line_mask = 9'h054;  // 2 4 6
      default: line_mask = 9'h000;
    endcase
  end

  assign mover_cells = turn_q ? bo_q : bx_q;
  assign line_won    = (mover_cells & line_mask) == line_mask;
  assign pos_mask    = 9'd1 << pos_q;
  assign cell_taken  = |((bx_q | bo_q) & pos_mask);

  // Cursor moves wrap within the current row / column.
  always_comb begin
    pos_right = pos_q + 4'd1;
    unique case (pos_q)
      4'd2:    pos_right = 4'd0;
      4'd5:    pos_right = 4'd3;
      4'd8:    pos_right = 4'd6;
      default: pos_right = pos_q + 4'd1;
    endcase
    pos_down = (pos_q >= 4'd6) ? (pos_q - 4'd6) : (pos_q + 4'd3);
  end

  // Game FSM with all outputs registered.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pos_q     <= 4'd0;
      counter_q <= 4'd0;
      bx_q      <= 9'd0;
      bo_q      <= 9'd0;
      turn_q    <= FIRST_PLAYER;
      k_q       <= 3'd0;
      xw_q      <= 1'b0;
      ow_q      <= 1'b0;
      draw_q    <= 1'b0;
      reject_q  <= 1'b0;
      p1s_q     <= 12'd0;
      p2s_q     <= 12'd0;
    end else begin
      reject_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.Start) begin
            state_q   <= StPlay;
            pos_q     <= 4'd0;
            counter_q <= 4'd0;
            bx_q      <= 9'd0;
            bo_q      <= 9'd0;
            turn_q    <= FIRST_PLAYER;
            k_q       <= 3'd0;
            xw_q      <= 1'b0;
            ow_q      <= 1'b0;
            draw_q    <= 1'b0;
            p1s_q     <= 12'd0;
            p2s_q     <= 12'd0;
          end
        end
        StPlay: begin
          if (bus.BtnU) begin
            if (cell_taken) begin
              reject_q <= 1'b1;
            end else begin
              if (turn_q) bo_q <= bo_q | pos_mask;
              else        bx_q <= bx_q | pos_mask;
              counter_q <= counter_q + 4'd1;
              k_q       <= 3'd0;
              state_q   <= StCheck;
            end
          end else if (bus.BtnR) begin
            pos_q <= pos_right;
          end else if (bus.BtnD) begin
            pos_q <= pos_down;
          end
        end
        StCheck: begin
          if (line_won) begin
            if (turn_q) begin
              ow_q <= 1'b1;
              if (p2s_q != 12'hfff) p2s_q <= p2s_q + 12'd1;
            end else begin
              xw_q <= 1'b1;
              if (p1s_q != 12'hfff) p1s_q <= p1s_q + 12'd1;
            end
            state_q <= StDone;
          end else if (k_q == 3'd7) begin
            if (counter_q == 4'd9) begin
              draw_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              turn_q  <= ~turn_q;
              state_q <= StPlay;
            end
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        StDone: begin
          // Rematch keeps the scores; Start takes priority over Ack.
          if (bus.Start) begin
            state_q   <= StPlay;
            pos_q     <= 4'd0;
            counter_q <= 4'd0;
            bx_q      <= 9'd0;
            bo_q      <= 9'd0;
            turn_q    <= FIRST_PLAYER;
            k_q       <= 3'd0;
            xw_q      <= 1'b0;
            ow_q      <= 1'b0;
            draw_q    <= 1'b0;
          end else if (bus.Ack) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pos     = pos_q;
  assign bus.board_x = bx_q;
  assign bus.board_o = bo_q;
  assign bus.turn    = turn_q;
  assign bus.Qi      = state_q[0];
  assign bus.Qp      = state_q[1];
  assign bus.Qc      = state_q[2];
  assign bus.Qd      = state_q[3];
  assign bus.Xwins   = xw_q;
  assign bus.Owins   = ow_q;
  assign bus.draw    = draw_q;
  assign bus.reject  = reject_q;
  assign bus.P1s     = p1s_q;
  assign bus.P2s     = p2s_q;

endmodule

// File: tb/tb_ttt_turn_sched.sv
// Self-checking bench for ttt_turn_sched: a board-level game model checked every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_ttt_turn_sched;
  localparam bit FP = 1'b0;

  logic Clk = 1'b0;
  logic reset_n = 1'b0;

  ttt_turn_sched_if bus ();

  ttt_turn_sched #(.FIRST_PLAYER(FP)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- game model ----------------
  // mode: 0 idle, 1 play, 2 check, 3 done. cell: 0 empty, 1 X, 2 O.
  int m_mode, m_row, m_col, m_turn, m_moves, m_line, m_s1, m_s2;
  int m_cell [9];
  bit m_xw, m_ow, m_draw, m_rej;
  int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                       '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  task automatic m_new_game(input bit clr_scores);
    foreach (m_cell[i]) m_cell[i] = 0;
    m_row = 0; m_col = 0; m_turn = int'(FP); m_moves = 0; m_line = 0;
    m_xw = 0; m_ow = 0; m_draw = 0;
    if (clr_scores) begin m_s1 = 0; m_s2 = 0; end
    m_mode = 1;
  endtask

  task automatic m_reset();
    m_new_game(1'b1);
    m_mode = 0;
    m_rej  = 0;
  endtask

  function automatic bit owns(input int who, input int l);
    return m_cell[lines[l][0]] == who + 1 && m_cell[lines[l][1]] == who + 1 &&
           m_cell[lines[l][2]] == who + 1;
  endfunction

  task automatic m_step(input bit st, input bit ak, input bit u, input bit r, input bit d);
    int idx;
    m_rej = 0;
    case (m_mode)
      0: if (st) m_new_game(1'b1);
      1: begin
        idx = m_row * 3 + m_col;
        if (u) begin
          if (m_cell[idx] != 0) m_rej = 1;
          else begin
            m_cell[idx] = m_turn + 1; m_moves++; m_line = 0; m_mode = 2;
          end
        end else if (r) m_col = (m_col + 1) % 3;
        else if (d) m_row = (m_row + 1) % 3;
      end
      2: begin
        if (owns(m_turn, m_line)) begin
          if (m_turn == 0) begin m_xw = 1; if (m_s1 < 4095) m_s1++; end
          else begin m_ow = 1; if (m_s2 < 4095) m_s2++; end
          m_mode = 3;
        end else if (m_line == 7) begin
          if (m_moves == 9) begin m_draw = 1; m_mode = 3; end
          else begin m_turn = 1 - m_turn; m_mode = 1; end
        end else m_line++;
      end
      3: if (st) m_new_game(1'b0); else if (ak) m_mode = 0;
      default: m_mode = 0;
    endcase
  endtask

  // Model advances on every edge the DUT would react to.
  initial begin
    m_reset();
    forever begin
      @(posedge Clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step(bus.Start, bus.Ack, bus.BtnU, bus.BtnR, bus.BtnD);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic [54:0] exp_v, act_v;
    logic [8:0]  ebx, ebo;
    forever begin
      @(negedge Clk);
      for (int i = 0; i < 9; i++) begin
        ebx[i] = (m_cell[i] == 1);
        ebo[i] = (m_cell[i] == 2);
      end
      exp_v = {4'(m_row * 3 + m_col), ebx, ebo, 1'(m_turn),
               m_mode == 0, m_mode == 1, m_mode == 2, m_mode == 3,
               m_xw, m_ow, m_draw, m_rej, 12'(m_s1), 12'(m_s2)};
      act_v = {bus.pos, bus.board_x, bus.board_o, bus.turn, bus.Qi, bus.Qp, bus.Qc, bus.Qd,
               bus.Xwins, bus.Owins, bus.draw, bus.reject, bus.P1s, bus.P2s};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_model @%0t: got %h required %h (pos|bx|bo|turn|Q|res|rej|P1s|P2s)",
                 $time, act_v, exp_v);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Called at a negedge: hold the given inputs for one cycle.
  task automatic drive(input bit st, input bit ak, input bit u, input bit r, input bit d);
    bus.Start = st; bus.Ack = ak; bus.BtnU = u; bus.BtnR = r; bus.BtnD = d;
    @(negedge Clk);
    bus.Start = 1'b0; bus.Ack = 1'b0; bus.BtnU = 1'b0; bus.BtnR = 1'b0; bus.BtnD = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 30 && bus.Qc; i++) @(negedge Clk);
    if (bus.Qc) begin
      n_checks++; n_fail++;
      $display("FAIL settle_timeout: got still in CHECK, required exit within 30 cycles");
    end
  endtask

  task automatic goto_cell(input int c);
    for (int i = 0; i < 3 && m_col != c % 3; i++) drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3 && m_row != c / 3; i++) drive(0, 0, 0, 0, 1);
  endtask

  task automatic place(input int c);
    goto_cell(c);
    drive(0, 0, 1, 0, 0);
    settle();
  endtask

  task automatic play(input int seq[9], input int n);
    for (int i = 0; i < n; i++) place(seq[i]);
  endtask

  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    @(negedge Clk);
    #2 reset_n = 1'b1;
    @(negedge Clk);
  endtask

  int win_seq  [9] = '{0, 3, 1, 4, 2, 0, 0, 0, 0};
  int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    int n;
    bus.Start = 1'b0; bus.Ack = 1'b0; bus.BtnU = 1'b0; bus.BtnR = 1'b0; bus.BtnD = 1'b0;
    cyc(3);
    reset_n = 1'b1;

    // Reset state
    check("rst_qi", int'(bus.Qi), 1);
    check("rst_pos", int'(bus.pos), 0);
    check("rst_turn", int'(bus.turn), int'(FP));
    check("rst_p1s", int'(bus.P1s), 0);

    // Without Start nothing happens
    drive(0, 1, 1, 1, 1);
    cyc(2);
    check("no_start_idle", int'(bus.Qi), 1);
    check("no_start_board", int'(bus.board_x), 0);

    drive(1, 0, 0, 0, 0);
    check("start_play", int'(bus.Qp), 1);

    // First placement: 8 CHECK cycles then O to move
    drive(0, 0, 1, 0, 0);
    check("first_bx", int'(bus.board_x), 1);
    n = 0;
    while (bus.Qc && n < 20) begin n++; cyc(1); end
    check("check_len", n, 8);
    check("after_turn", int'(bus.turn), 1);
    check("after_play", int'(bus.Qp), 1);

    // Cursor wraps and button priority
    drive(0, 0, 0, 1, 0); drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 1);
    check("pos_to_8", int'(bus.pos), 8);
    drive(0, 0, 0, 1, 0);
    check("right_wrap_8_6", int'(bus.pos), 6);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    check("down_wrap_7_1", int'(bus.pos), 1);
    drive(0, 0, 1, 1, 0);
    check("u_r_pos_kept", int'(bus.pos), 1);
    check("u_r_placed", int'(bus.board_o), 9'h002);
    settle();

    // Rejected placement on an occupied cell
    drive(0, 0, 1, 0, 0);
    check("reject_pulse", int'(bus.reject), 1);
    check("reject_bx", int'(bus.board_x), 9'h001);
    check("reject_bo", int'(bus.board_o), 9'h002);
    check("reject_turn", int'(bus.turn), 0);
    cyc(1);
    check("reject_one_cycle", int'(bus.reject), 0);

    // Reset in the middle of evaluating a winning move
    place(3); place(4); goto_cell(6);
    drive(0, 0, 1, 0, 0);
    cyc(1);
    #2 reset_n = 1'b0;
    #1;
    check("midchk_idle", int'(bus.Qi), 1);
    check("midchk_bx", int'(bus.board_x), 0);
    check("midchk_xwins", int'(bus.Xwins), 0);
    @(negedge Clk);
    #2 reset_n = 1'b1;
    @(negedge Clk);
    cyc(3);
    check("midchk_still_idle", int'(bus.Qi), 1);
    check("midchk_p1s", int'(bus.P1s), 0);

    // Top-row X win
    drive(1, 0, 0, 0, 0);
    play(win_seq, 4);
    goto_cell(2);
    drive(0, 0, 1, 0, 0);
    check("win_in_check", int'(bus.Qc), 1);
    cyc(1);
    check("win_qd", int'(bus.Qd), 1);
    check("win_xwins", int'(bus.Xwins), 1);
    check("win_owins", int'(bus.Owins), 0);
    check("win_p1s", int'(bus.P1s), 1);

    // Rematch keeps scores, then a drawn game
    drive(1, 0, 0, 0, 0);
    check("rematch_board", int'(bus.board_x), 0);
    check("rematch_p1s", int'(bus.P1s), 1);
    play(draw_seq, 9);
    check("draw_qd", int'(bus.Qd), 1);
    check("draw_flag", int'(bus.draw), 1);
    check("draw_xwins", int'(bus.Xwins), 0);
    check("draw_p1s", int'(bus.P1s), 1);
    check("draw_p2s", int'(bus.P2s), 0);

    // Start beats Ack
    drive(1, 1, 0, 0, 0);
    check("start_over_ack", int'(bus.Qp), 1);
    check("start_over_ack_p1s", int'(bus.P1s), 1);
    play(win_seq, 5);
    check("second_win_p1s", int'(bus.P1s), 2);
    drive(0, 1, 0, 0, 0);
    check("ack_idle", int'(bus.Qi), 1);
    check("ack_held_xwins", int'(bus.Xwins), 1);
    drive(1, 0, 0, 0, 0);
    check("idle_start_clears", int'(bus.P1s), 0);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) reset_pulse();
      else drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0);
    end

    // Score saturation
    reset_pulse();
    drive(1, 0, 0, 0, 0);
    play(win_seq, 5);
    check("sat_pre_p1s", int'(bus.P1s), 1);
    #2;
    force dut.p1s_q = 12'd4094;
    m_s1 = 4094;
    #1 release dut.p1s_q;
    @(negedge Clk);
    drive(1, 0, 0, 0, 0);
    play(win_seq, 5);
    check("sat_reach", int'(bus.P1s), 4095);
    drive(1, 0, 0, 0, 0);
    play(win_seq, 5);
    check("sat_hold_xwins", int'(bus.Xwins), 1);
    check("sat_hold", int'(bus.P1s), 4095);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
